// File: rtl/sprite_draw_engine.sv
// Sprite blitter: walks one sprite frame out of a registered-read ROM and writes every
// opaque, on-screen pixel to the frame buffer, then holds done until the request drops.
module sprite_draw_engine #(
    parameter int SPR_W       = 16,
    parameter int SPR_H       = 16,
    parameter int SCREEN_W    = 160,
    parameter int SCREEN_H    = 120,
    parameter int X_W         = 8,
    parameter int Y_W         = 7,
    parameter int FRAME_W     = 3,
    parameter int COLOR_W     = 3,
    parameter int TRANSPARENT = 0
) (
    input  logic                                      clock,
    input  logic                                      reset,
    input  logic                                      start,
    input  logic [X_W-1:0]                            pos_x,
    input  logic [Y_W-1:0]                            pos_y,
    input  logic [FRAME_W-1:0]                        frame,
    output logic [FRAME_W+$clog2(SPR_W*SPR_H)-1:0]    rom_addr,
    input  logic [COLOR_W-1:0]                        rom_data,
    output logic [X_W-1:0]                            fb_x,
    output logic [Y_W-1:0]                            fb_y,
    output logic [COLOR_W-1:0]                        fb_colour,
    output logic                                      fb_we,
    output logic                                      busy,
    output logic                                      done
);
    localparam int COL_W = $clog2(SPR_W);
    localparam int ROW_W = $clog2(SPR_H);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [X_W-1:0]     pos_x_q, pos_x_d;
    logic [Y_W-1:0]     pos_y_q, pos_y_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic               valid_q, valid_d;
    // One extra bit so pixels past the right/bottom edge are clipped rather than wrapped
    logic [X_W:0]       sx_q, sx_d;
    logic [Y_W:0]       sy_q, sy_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            pos_x_q <= '0;
            pos_y_q <= '0;
            frame_q <= '0;
            row_q   <= '0;
            col_q   <= '0;
            valid_q <= 1'b0;
            sx_q    <= '0;
            sy_q    <= '0;
        end else begin
            state_q <= state_d;
            pos_x_q <= pos_x_d;
            pos_y_q <= pos_y_d;
            frame_q <= frame_d;
            row_q   <= row_d;
            col_q   <= col_d;
            valid_q <= valid_d;
            sx_q    <= sx_d;
            sy_q    <= sy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pos_x_d = pos_x_q;
        pos_y_d = pos_y_q;
        frame_d = frame_q;
        row_d   = row_q;
        col_d   = col_q;
        valid_d = 1'b0;
        sx_d    = sx_q;
        sy_d    = sy_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    pos_x_d = pos_x;
                    pos_y_d = pos_y;
                    frame_d = frame;
                    row_d   = '0;
                    col_d   = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                valid_d = 1'b1;
                sx_d    = {1'b0, pos_x_q} + (X_W+1)'(col_q);
                sy_d    = {1'b0, pos_y_q} + (Y_W+1)'(row_q);
                col_d   = col_q + 1'b1;
                if (col_q == COL_W'(SPR_W - 1)) begin
                    row_d = row_q + 1'b1;
                    if (row_q == ROW_W'(SPR_H - 1)) begin
                        state_d = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                if (!start) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign rom_addr  = {frame_q, row_q, col_q};
    assign fb_x      = sx_q[X_W-1:0];
    assign fb_y      = sy_q[Y_W-1:0];
    assign fb_colour = rom_data;
    assign fb_we     = valid_q
                     && (sx_q < (X_W+1)'(SCREEN_W))
                     && (sy_q < (Y_W+1)'(SCREEN_H))
                     && (rom_data != COLOR_W'(TRANSPARENT));
    assign busy      = (state_q == S_FETCH) || (state_q == S_FLUSH);
    assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_sprite_draw_engine.sv
// Directed bench for sprite_draw_engine: table of full passes plus a mid-run reset sequence.
module tb_sprite_draw_engine;
    logic        clock;
    logic        reset;
    logic        start;
    logic [7:0]  pos_x;
    logic [6:0]  pos_y;
    logic [2:0]  frame;
    logic [10:0] rom_addr;
    logic [2:0]  rom_data;
    logic [7:0]  fb_x;
    logic [6:0]  fb_y;
    logic [2:0]  fb_colour;
    logic        fb_we;
    logic        busy;
    logic        done;

    sprite_draw_engine dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .pos_x     (pos_x),
        .pos_y     (pos_y),
        .frame     (frame),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .fb_x      (fb_x),
        .fb_y      (fb_y),
        .fb_colour (fb_colour),
        .fb_we     (fb_we),
        .busy      (busy),
        .done      (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Sprite ROM contents: frame 2 solid 5, frame 1 checkerboard 0/7, frame 0 solid 6, rest 3
    function automatic int pix(int f, int r, int c);
        if (f == 2) return 5;
        if (f == 1) return (((r + c) % 2) == 1) ? 7 : 0;
        if (f == 0) return 6;
        return 3;
    endfunction

    logic [2:0] rom_mem [0:2047];
    always @(posedge clock) rom_data <= rom_mem[rom_addr];

    typedef struct {
        int cyc;
        int x;
        int y;
        int col;
    } wr_t;

    wr_t got_q[$];
    wr_t exp_q[$];
    int  cyc;
    int  first_done;
    int  done_cnt;
    int  busy_cnt;
    int  tests;
    int  failed;

    always @(negedge clock) begin
        if (fb_we) got_q.push_back('{cyc, int'(fb_x), int'(fb_y), int'(fb_colour)});
        if (done) begin
            done_cnt++;
            if (first_done < 0) first_done = cyc;
        end
        if (busy) busy_cnt++;
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    typedef struct {
        int px;
        int py;
        int fr;
        int drop_cyc;
        int chg_cyc;
        int exp_writes;
        int exp_done;
        int exp_done_len;
    } vec_t;

    vec_t vecs [5];

    task automatic clear_stats();
        got_q.delete();
        exp_q.delete();
        first_done = -1;
        done_cnt   = 0;
        busy_cnt   = 0;
    endtask

    // Reference: pixel k issued in cycle k+1, written in cycle k+2 when opaque and on-screen
    task automatic build_expected(input int px, input int py, input int fr);
        for (int k = 0; k < 256; k++) begin
            int r, c, sx, sy, col;
            r   = k / 16;
            c   = k % 16;
            sx  = px + c;
            sy  = py + r;
            col = pix(fr, r, c);
            if (sx < 160 && sy < 120 && col != 0) exp_q.push_back('{k + 2, sx, sy, col});
        end
    endtask

    task automatic compare_writes(input string tag);
        int n;
        check({tag, " write_count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check({tag, " write"},
                  (got_q[i].cyc << 18) | (got_q[i].x << 10) | (got_q[i].y << 3) | got_q[i].col,
                  (exp_q[i].cyc << 18) | (exp_q[i].x << 10) | (exp_q[i].y << 3) | exp_q[i].col);
        end
    endtask

    task automatic run_vector(input int idx);
        vec_t v;
        string tag;
        int drop_at;
        v   = vecs[idx];
        tag = $sformatf("vec%0d", idx);
        clear_stats();
        build_expected(v.px, v.py, v.fr);
        @(posedge clock); #1;
        pos_x = 8'(v.px);
        pos_y = 7'(v.py);
        frame = 3'(v.fr);
        start = 1'b1;
        cyc   = 0;
        for (int c = 1; c <= 300; c++) begin
            @(posedge clock); #1;
            cyc = c;
            if (v.chg_cyc == c) begin
                pos_x = 8'd0;
                pos_y = 7'd0;
                frame = 3'd1;
            end
            drop_at = (v.drop_cyc >= 0) ? v.drop_cyc : ((first_done >= 0) ? first_done + 10 : 268);
            if (c == drop_at) start = 1'b0;
        end
        @(negedge clock);
        check({tag, " writes_hand"}, got_q.size(), v.exp_writes);
        compare_writes(tag);
        check({tag, " done_cycle"}, first_done, v.exp_done);
        check({tag, " done_len"}, done_cnt, v.exp_done_len);
        check({tag, " busy_cycles"}, busy_cnt, 257);
        check({tag, " done_low_end"}, int'(done), 0);
        $display("[TB] pass %0d pos=(%0d,%0d) frame=%0d writes=%0d done@%0d len=%0d busy=%0d",
                 idx, v.px, v.py, v.fr, got_q.size(), first_done, done_cnt, busy_cnt);
    endtask

    initial begin
        tests  = 0;
        failed = 0;
        cyc    = 0;
        for (int a = 0; a < 2048; a++) rom_mem[a] = 3'(pix(a >> 8, (a >> 4) & 15, a & 15));
        vecs[0] = '{10,  20,  2, -1,  -1, 256, 258, 11};
        vecs[1] = '{40,  30,  1, -1,  -1, 128, 258, 11};
        vecs[2] = '{150, 112, 2, -1,  -1, 80,  258, 11};
        vecs[3] = '{10,  20,  2, 100, -1, 256, 258, 1};
        vecs[4] = '{60,  50,  2, -1,  30, 256, 258, 11};

        reset = 1'b1;
        start = 1'b0;
        pos_x = '0;
        pos_y = '0;
        frame = '0;
        clear_stats();
        repeat (3) @(posedge clock);
        #1;
        check("reset done", int'(done), 0);
        check("reset busy", int'(busy), 0);
        check("reset fb_we", int'(fb_we), 0);
        check("reset rom_addr", int'(rom_addr), 0);
        $display("[TB] reset state done=%0d busy=%0d fb_we=%0d rom_addr=%0d", done, busy, fb_we, rom_addr);
        @(posedge clock); #1;
        reset = 1'b0;

        for (int i = 0; i < 5; i++) run_vector(i);

        // Mid-run reset: pixels 0..48 land in cycles 2..50, nothing from cycle 51 on
        clear_stats();
        @(posedge clock); #1;
        pos_x = 8'd10;
        pos_y = 7'd20;
        frame = 3'd2;
        start = 1'b1;
        cyc   = 0;
        for (int c = 1; c <= 320; c++) begin
            @(posedge clock); #1;
            cyc = c;
            if (c == 50) begin
                reset = 1'b1;
                start = 1'b0;
            end
            if (c == 51) begin
                reset = 1'b0;
                check("rst busy_c51", int'(busy), 0);
            end
        end
        @(negedge clock);
        check("rst writes_before", got_q.size(), 49);
        if (got_q.size() > 0) check("rst last_write_cyc", got_q[got_q.size() - 1].cyc, 50);
        check("rst busy_cycles", busy_cnt, 50);
        check("rst done_count", done_cnt, 0);
        $display("[TB] reset-mid-run writes=%0d busy=%0d done=%0d", got_q.size(), busy_cnt, done_cnt);

        run_vector(0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
